// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared FSM/phase types and UART register map for the RSA Avalon wrapper
package rsa_pkg;

   typedef enum logic [2:0] {
      S_QUERY_RX,
      S_READ,
      S_CALC,
      S_QUERY_TX,
      S_WRITE
   } state_t;

   typedef enum logic [1:0] {
      PH_N,
      PH_D,
      PH_DATA
   } phase_t;

   typedef logic [255:0] word_t;

   localparam logic [4:0] RX_BASE     = 5'd0;
   localparam logic [4:0] TX_BASE     = 5'd4;
   localparam logic [4:0] STATUS_BASE = 5'd8;
   localparam int         RX_OK_BIT   = 7;
   localparam int         TX_OK_BIT   = 6;

   // Counter values of the last byte of a 256-bit load and of a 248-bit reply.
   localparam logic [5:0] RX_LAST_BYTE = 6'd31;
   localparam logic [5:0] TX_LAST_BYTE = 6'd30;

endpackage

// File: rtl/rsa_avalon_wrapper.sv
// rtl/rsa_avalon_wrapper.sv - polls the UART over Avalon-MM, loads N/D/cipher into the RSA core
// and returns each 248-bit plaintext one byte at a time
module rsa_avalon_wrapper
   import rsa_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   output logic [4:0]   avm_address,
   output logic         avm_read,
   input  logic [31:0]  avm_readdata,
   output logic         avm_write,
   output logic [31:0]  avm_writedata,
   input  logic         avm_waitrequest,
   output logic         o_core_start,
   output logic [255:0] o_core_a,
   output logic [255:0] o_core_d,
   output logic [255:0] o_core_n,
   input  logic [255:0] i_core_a_pow_d,
   input  logic         i_core_finished
);

   state_t       state, state_nx;
   phase_t       phase, phase_nx;
   logic [5:0]   cnt, cnt_nx;
   logic [4:0]   addr_nx;
   logic         rd_nx;
   logic         wr_nx;
   logic [31:0]  wdata_nx;
   logic         start_nx;
   logic [247:0] plain;
   logic         rx_take;
   logic         tx_take;
   logic         plain_load;
   logic         xfer_done;
   logic         unused_bits;

   assign xfer_done   = (avm_read | avm_write) & ~avm_waitrequest;
   assign unused_bits = ^{avm_readdata[31:8], i_core_a_pow_d[255:248]};

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state         <= S_QUERY_RX;
         phase         <= PH_N;
         cnt           <= '0;
         avm_address   <= STATUS_BASE;
         avm_read      <= 1'b1;
         avm_write     <= 1'b0;
         avm_writedata <= '0;
         o_core_start  <= 1'b0;
      end else begin
         state         <= state_nx;
         phase         <= phase_nx;
         cnt           <= cnt_nx;
         avm_address   <= addr_nx;
         avm_read      <= rd_nx;
         avm_write     <= wr_nx;
         avm_writedata <= wdata_nx;
         o_core_start  <= start_nx;
      end
   end

   // Operand registers fill MSB byte first; the plaintext drains from its top byte.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_core_n <= '0;
         o_core_d <= '0;
         o_core_a <= '0;
         plain    <= '0;
      end else begin
         if (rx_take) begin
            case (phase)
               PH_N:    o_core_n <= {o_core_n[247:0], avm_readdata[7:0]};
               PH_D:    o_core_d <= {o_core_d[247:0], avm_readdata[7:0]};
               default: o_core_a <= {o_core_a[247:0], avm_readdata[7:0]};
            endcase
         end
         if (plain_load) begin
            plain <= i_core_a_pow_d[247:0];
         end else if (tx_take) begin
            plain <= {plain[239:0], 8'h00};
         end
      end
   end

   always_comb begin
      state_nx   = state;
      phase_nx   = phase;
      cnt_nx     = cnt;
      addr_nx    = avm_address;
      rd_nx      = avm_read;
      wr_nx      = avm_write;
      wdata_nx   = avm_writedata;
      start_nx   = 1'b0;
      rx_take    = 1'b0;
      tx_take    = 1'b0;
      plain_load = 1'b0;
      case (state)
         S_QUERY_RX: begin
            if (xfer_done && avm_readdata[RX_OK_BIT]) begin
               state_nx = S_READ;
               addr_nx  = RX_BASE;
            end
         end
         S_READ: begin
            if (xfer_done) begin
               rx_take  = 1'b1;
               cnt_nx   = cnt + 6'd1;
               state_nx = S_QUERY_RX;
               addr_nx  = STATUS_BASE;
               if (cnt == RX_LAST_BYTE) begin
                  cnt_nx = '0;
                  if (phase == PH_DATA) begin
                     state_nx = S_CALC;
                     rd_nx    = 1'b0;
                     start_nx = 1'b1;
                  end else begin
                     phase_nx = (phase == PH_N) ? PH_D : PH_DATA;
                  end
               end
            end
         end
         S_CALC: begin
            if (i_core_finished) begin
               plain_load = 1'b1;
               state_nx   = S_QUERY_TX;
               rd_nx      = 1'b1;
               addr_nx    = STATUS_BASE;
            end
         end
         S_QUERY_TX: begin
            if (xfer_done && avm_readdata[TX_OK_BIT]) begin
               state_nx = S_WRITE;
               rd_nx    = 1'b0;
               wr_nx    = 1'b1;
               addr_nx  = TX_BASE;
               wdata_nx = {24'h000000, plain[247:240]};
            end
         end
         S_WRITE: begin
            if (xfer_done) begin
               tx_take  = 1'b1;
               cnt_nx   = cnt + 6'd1;
               wr_nx    = 1'b0;
               rd_nx    = 1'b1;
               addr_nx  = STATUS_BASE;
               state_nx = S_QUERY_TX;
               if (cnt == TX_LAST_BYTE) begin
                  cnt_nx   = '0;
                  state_nx = S_QUERY_RX;
               end
            end
         end
         default: begin
            state_nx = S_QUERY_RX;
            rd_nx    = 1'b1;
            wr_nx    = 1'b0;
            addr_nx  = STATUS_BASE;
         end
      endcase
   end

endmodule

// File: tb/tb_rsa_avalon_wrapper.sv
// tb/tb_rsa_avalon_wrapper.sv - self-checking bench: UART slave model, behavioural core stub,
// RSA vector table, randomized blocks and reset corner cases
module tb_rsa_avalon_wrapper;
   import rsa_pkg::*;

   logic         i_clk;
   logic         i_rst;
   logic [4:0]   avm_address;
   logic         avm_read;
   logic [31:0]  avm_readdata;
   logic         avm_write;
   logic [31:0]  avm_writedata;
   logic         avm_waitrequest;
   logic         o_core_start;
   logic [255:0] o_core_a;
   logic [255:0] o_core_d;
   logic [255:0] o_core_n;
   logic [255:0] i_core_a_pow_d;
   logic         i_core_finished;

   rsa_avalon_wrapper dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .o_core_start    (o_core_start),
      .o_core_a        (o_core_a),
      .o_core_d        (o_core_d),
      .o_core_n        (o_core_n),
      .i_core_a_pow_d  (i_core_a_pow_d),
      .i_core_finished (i_core_finished)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]   rxq[$];
   logic [7:0]   txlog[$];
   int           status_reads = 0;
   int           rx_reads = 0;
   int           tx_writes = 0;
   int           rx_hold = 0;
   int           tx_hold = 0;
   int           rx_stall_next = 0;
   int           tx_stall_next = 0;
   bit           random_wait = 1'b0;

   logic [255:0] cap_a[$];
   logic [255:0] cap_d[$];
   logic [255:0] cap_n[$];
   logic [255:0] exp_res[$];
   int           starts = 0;
   bit           stub_random = 1'b0;
   bit           spurious_req = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] e,
                                           input logic [255:0] m);
      logic [511:0] r, x, mm;
      mm = {256'd0, m};
      r  = 512'd1 % mm;
      x  = {256'd0, b} % mm;
      for (int i = 0; i < 256; i++) begin
         if (e[i]) r = (r * x) % mm;
         x = (x * x) % mm;
      end
      return r[255:0];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic push_word(input logic [255:0] w);
      for (int i = 31; i >= 0; i--) rxq.push_back(w[i*8 +: 8]);
   endtask

   function automatic logic [255:0] tx_value(input int first);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < 31; i++)
         if (first + i < txlog.size()) v = {v[247:0], txlog[first + i]};
      return v;
   endfunction

   function automatic int counter(input int sel);
      case (sel)
         0:       return rx_reads;
         1:       return tx_writes;
         2:       return starts;
         default: return status_reads;
      endcase
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic wait_for(input int sel, input int target, input string name);
      int cyc;
      cyc = 0;
      while (counter(sel) < target && cyc < 5000) begin
         @(negedge i_clk);
         cyc++;
      end
      if (counter(sel) < target) begin
         checks++;
         errors++;
         $display("FAIL %s: timed out at count %0d, required %0d", name, counter(sel), target);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_address"}, avm_address, STATUS_BASE);
      check({tag, "_read"}, avm_read, 1'b1);
      check({tag, "_write"}, avm_write, 1'b0);
      check({tag, "_writedata"}, avm_writedata, 32'd0);
      check({tag, "_start"}, o_core_start, 1'b0);
      check({tag, "_core_a"}, o_core_a, 256'd0);
      check({tag, "_core_d"}, o_core_d, 256'd0);
      check({tag, "_core_n"}, o_core_n, 256'd0);
   endtask

   // UART slave: decides waitrequest/readdata mid-cycle for the coming edge and logs completions
   initial begin : uart_slave
      int          stall_left;
      bit          pending;
      logic [38:0] held;
      stall_left      = 0;
      pending         = 1'b0;
      held            = '0;
      avm_waitrequest = 1'b1;
      avm_readdata    = '0;
      forever begin
         @(negedge i_clk);
         avm_readdata = $urandom;
         if (!i_rst) begin
            pending         = 1'b0;
            avm_waitrequest = 1'b1;
         end else begin
            if (avm_read && avm_write) check("read_write_exclusive", 1'b1, 1'b0);
            if (pending) check("avalon_hold", {avm_read, avm_write, avm_address, avm_writedata}, held);
            if (avm_read || avm_write) begin
               if (!pending) begin
                  stall_left = 0;
                  if (avm_read && avm_address == RX_BASE) begin
                     stall_left    = rx_stall_next;
                     rx_stall_next = 0;
                  end
                  if (avm_write && avm_address == TX_BASE) begin
                     stall_left    = tx_stall_next;
                     tx_stall_next = 0;
                  end
                  if (random_wait) stall_left += $urandom_range(0, 2);
               end
               if (stall_left > 0) begin
                  stall_left--;
                  pending         = 1'b1;
                  held            = {avm_read, avm_write, avm_address, avm_writedata};
                  avm_waitrequest = 1'b1;
               end else begin
                  pending         = 1'b0;
                  avm_waitrequest = 1'b0;
                  if (avm_write) begin
                     check("write_address", avm_address, TX_BASE);
                     check("writedata_upper", avm_writedata[31:8], 24'd0);
                     txlog.push_back(avm_writedata[7:0]);
                     tx_writes++;
                  end else if (avm_address == STATUS_BASE) begin
                     avm_readdata[RX_OK_BIT] = (rxq.size() > 0) && (rx_hold == 0);
                     avm_readdata[TX_OK_BIT] = (tx_hold == 0);
                     status_reads++;
                     if (rx_hold > 0) rx_hold--;
                     if (tx_hold > 0) tx_hold--;
                  end else begin
                     check("read_address", avm_address, RX_BASE);
                     check("rx_read_has_data", rxq.size() > 0, 1'b1);
                     if (rxq.size() > 0) avm_readdata[7:0] = rxq.pop_front();
                     rx_reads++;
                  end
               end
            end else begin
               pending         = 1'b0;
               avm_waitrequest = 1'b0;
            end
         end
      end
   end

   // Core stub: a^d mod n (or a random word) returned 10 cycles after start
   initial begin : core_stub
      logic [255:0] a, d, n, r;
      bit           aborted;
      i_core_finished = 1'b0;
      i_core_a_pow_d  = '0;
      forever begin
         @(negedge i_clk);
         i_core_finished = 1'b0;
         if (spurious_req) begin
            spurious_req    = 1'b0;
            i_core_a_pow_d  = rand256();
            i_core_finished = 1'b1;
         end else if (i_rst && o_core_start) begin
            starts++;
            a = o_core_a;
            d = o_core_d;
            n = o_core_n;
            cap_a.push_back(a);
            cap_d.push_back(d);
            cap_n.push_back(n);
            r = stub_random ? rand256() : ((n != 0) ? modexp(a, d, n) : 256'd0);
            aborted = 1'b0;
            for (int k = 1; k <= 10; k++) begin
               @(negedge i_clk);
               if (!i_rst) begin
                  aborted = 1'b1;
                  break;
               end
               if (k == 1) check("start_one_cycle", o_core_start, 1'b0);
               check("core_a_stable", o_core_a, a);
               check("core_d_stable", o_core_d, d);
               check("core_n_stable", o_core_n, n);
            end
            if (!aborted) begin
               exp_res.push_back(r);
               i_core_a_pow_d  = r;
               i_core_finished = 1'b1;
            end
         end
      end
   end

   task automatic run_block(input logic [255:0] cipher, input logic [255:0] plain,
                            input logic [255:0] exp_n, input logic [255:0] exp_d,
                            input int rx_stall, input int tx_stall, input int hold,
                            input string tag);
      int           t0, r0, s0, e0, guard;
      logic [255:0] expect_plain;
      t0 = tx_writes;
      r0 = rx_reads;
      s0 = starts;
      e0 = exp_res.size();
      rx_stall_next = rx_stall;
      push_word(cipher);
      wait_for(2, s0 + 1, {tag, "_start"});
      tx_stall_next = tx_stall;
      tx_hold = hold;
      guard = 0;
      while (tx_hold > 0 && guard < 1000) begin
         @(negedge i_clk);
         guard++;
      end
      if (hold > 0) check({tag, "_tx_not_ready_no_write"}, tx_writes, t0);
      wait_for(1, t0 + 31, {tag, "_tx"});
      wait_cycles(10);
      check({tag, "_tx_count"}, tx_writes - t0, 31);
      check({tag, "_rx_count"}, rx_reads - r0, 32);
      check({tag, "_start_count"}, starts - s0, 1);
      if (cap_a.size() > 0) begin
         check({tag, "_core_a"}, cap_a[cap_a.size() - 1], cipher);
         check({tag, "_core_n"}, cap_n[cap_n.size() - 1], exp_n);
         check({tag, "_core_d"}, cap_d[cap_d.size() - 1], exp_d);
      end
      expect_plain = plain;
      if (stub_random && exp_res.size() > e0) expect_plain = {8'h00, exp_res[e0][247:0]};
      check({tag, "_plaintext"}, tx_value(t0), expect_plain);
   endtask

   typedef struct {
      logic [255:0] cipher;
      logic [255:0] plain;
      int           rx_stall;
      int           tx_stall;
      int           tx_hold;
   } vec_t;

   vec_t vecs[4];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      logic [255:0] rn, rd, ra;
      int           t0, r0, s0, guard;

      // Textbook RSA pair n = 61*53, d = 2753: ciphertext -> plaintext
      vecs[0] = '{256'd2790, 256'd65,  5, 5, 10};
      vecs[1] = '{256'd855,  256'd123, 0, 0, 0};
      vecs[2] = '{256'd0,    256'd0,   0, 0, 0};
      vecs[3] = '{256'd1,    256'd1,   2, 3, 0};

      i_rst = 1'b1;
      #3 i_rst = 1'b0;
      wait_cycles(3);
      check_reset_values("reset");
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      check("release_read", avm_read, 1'b1);
      check("release_address", avm_address, STATUS_BASE);

      // Key load with 10 not-ready polls and a stalled first byte
      rx_hold = 10;
      rx_stall_next = 5;
      push_word(256'd3233);
      push_word(256'd2753);
      guard = 0;
      while (rx_hold > 0 && guard < 1000) begin
         @(negedge i_clk);
         guard++;
      end
      check("rx_not_ready_polls", status_reads >= 10, 1'b1);
      check("rx_not_ready_no_read", rx_reads, 0);
      wait_for(0, 64, "key_load");
      wait_cycles(5);
      check("key_n", o_core_n, 256'd3233);
      check("key_d", o_core_d, 256'd2753);
      check("key_no_start", starts, 0);
      check("key_rx_reads", rx_reads, 64);

      for (int i = 0; i < 4; i++)
         run_block(vecs[i].cipher, vecs[i].plain, 256'd3233, 256'd2753,
                   vecs[i].rx_stall, vecs[i].tx_stall, vecs[i].tx_hold, $sformatf("vec%0d", i));

      t0 = tx_writes;
      s0 = starts;
      spurious_req = 1'b1;
      wait_cycles(30);
      check("spurious_finish_no_tx", tx_writes, t0);
      check("spurious_finish_no_start", starts, s0);

      @(negedge i_clk);
      #2 i_rst = 1'b0;
      #1 check_reset_values("reset_pre_random");
      wait_cycles(2);
      i_rst = 1'b1;
      random_wait = 1'b1;
      stub_random = 1'b1;
      rn = rand256();
      rd = rand256();
      r0 = rx_reads;
      push_word(rn);
      push_word(rd);
      wait_for(0, r0 + 64, "rand_key");
      wait_cycles(5);
      check("rand_key_n", o_core_n, rn);
      check("rand_key_d", o_core_d, rd);
      for (int i = 0; i < 3; i++) begin
         ra = rand256();
         run_block(ra, 256'd0, rn, rd, $urandom_range(0, 3), $urandom_range(0, 3), 0,
                   $sformatf("rand%0d", i));
      end

      // Reset after 12 of 31 plaintext bytes
      ra = rand256();
      t0 = tx_writes;
      s0 = starts;
      push_word(ra);
      wait_for(1, t0 + 12, "mid_tx_progress");
      #2 i_rst = 1'b0;
      #1 check_reset_values("reset_mid_tx");
      wait_cycles(3);
      i_rst = 1'b1;
      wait_cycles(40);
      check("mid_tx_no_more_writes", tx_writes, t0 + 12);
      rn = rand256();
      r0 = rx_reads;
      push_word(rn);
      wait_for(0, r0 + 32, "mid_tx_reload");
      wait_cycles(5);
      check("mid_tx_reload_n", o_core_n, rn);
      check("mid_tx_reload_d", o_core_d, 256'd0);
      check("mid_tx_no_new_start", starts, s0 + 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
